// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed hex display scanner: gap/drive anode sequencing,
// shadow-buffered updates applied only at frame boundaries, leading-zero suppression.
module seg_scan_ctrl #(
    parameter int unsigned DWELL = 1000,
    parameter int unsigned GAP   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic [3:0]  blank_mask,
    input  logic        lzs,
    output logic [3:0]  nib,
    output logic [3:0]  an,
    output logic        pend,
    output logic        frame_start
);

    localparam int unsigned CMAX = (DWELL > GAP) ? DWELL : GAP;
    localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

    typedef enum logic {S_GAP, S_DRIVE} state_t;

    state_t        state, state_n;
    logic [1:0]    d, d_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [15:0]   disp, disp_n;
    logic [15:0]   shadow;
    logic          started;
    logic          boundary;
    logic [3:0]    lz;
    logic          blank;

    // Outputs are registered from the next-state values so that an/nib/frame_start
    // describe the same cycle that state/d/cnt describe.
    always_comb begin
        state_n  = state;
        d_n      = d;
        cnt_n    = cnt;
        boundary = 1'b0;
        if (!started) begin
            // first cycle after reset opens a fresh frame
            state_n  = S_GAP;
            d_n      = 2'd0;
            cnt_n    = '0;
            boundary = 1'b1;
        end else begin
            case (state)
                S_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_n = S_DRIVE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                S_DRIVE: begin
                    if (cnt == DWELL_LAST) begin
                        state_n  = S_GAP;
                        d_n      = d + 2'd1;
                        cnt_n    = '0;
                        boundary = (d == 2'd3);
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = S_GAP;
                    cnt_n   = '0;
                end
            endcase
        end

        disp_n = (boundary && pend) ? shadow : disp;

        lz[0] = 1'b0;
        lz[1] = (disp_n[15:4]  == 12'h000);
        lz[2] = (disp_n[15:8]  == 8'h00);
        lz[3] = (disp_n[15:12] == 4'h0);
        blank = blank_mask[d_n] | (lzs & lz[d_n]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_GAP;
            d           <= 2'd0;
            cnt         <= '0;
            disp        <= '0;
            shadow      <= '0;
            pend        <= 1'b0;
            started     <= 1'b0;
            an          <= '1;
            nib         <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            d           <= d_n;
            cnt         <= cnt_n;
            disp        <= disp_n;
            started     <= 1'b1;
            if (load)
                shadow <= data_in;
            // a load on the transfer edge keeps pend set for the new shadow value
            pend        <= load | (pend & ~boundary);
            an          <= (state_n == S_DRIVE && !blank) ? ~(4'b0001 << d_n) : 4'b1111;
            nib         <= disp_n[{d_n, 2'b00} +: 4];
            frame_start <= boundary;
        end
    end

endmodule
